sort_cnt_scan: RTL and testbench
================================

// Module: sort_cnt_scan
// PURPOSE
// - Read-side engine for the counting-sort count memory (sort_cnt_mem).
// - On start, scans every address/bank of the count memory and emits each key value
//   once per stored count, in ascending key order, on a valid/ready output stream.
// - Sits between the count memory read port and the downstream sorted-output consumer.
// - Key = addr*NUM_BANKS + bank.
// PARAMETERS
// - DATA_WIDTH  8  width of one count entry
// - ADDR_WIDTH  4  count memory address width; depth = 2**ADDR_WIDTH
// - NUM_BANKS   2  banks read in parallel per address; power of two, >=2
// - BANK_W      $clog2(NUM_BANKS)  localparam
// - KEY_W       ADDR_WIDTH+BANK_W  localparam
// PORTS
// - clk          in   1                     clock
// - rst          in   1                     synchronous reset, active-high
// - start        in   1                     begin a scan; sampled only in IDLE
// - busy         out  1                     high from the cycle after start until done
// - done         out  1                     one-cycle pulse after the final key is handled
// - mem_rd_en    out  NUM_BANKS             read enable, all bits driven together
// - mem_rd_addr  out  ADDR_WIDTH            read address
// - mem_rd_data  in   NUM_BANKS*DATA_WIDTH  registered read data, valid 1 cycle after mem_rd_en
// - mem_wr_en    out  NUM_BANKS             clear write enable (see CONFIGURATION)
// - mem_wr_addr  out  ADDR_WIDTH            clear write address
// - mem_wr_data  out  NUM_BANKS*DATA_WIDTH  clear write data, always 0
// - out_valid    out  1                     sorted key available
// - out_ready    in   1                     consumer accepts key
// - out_data     out  KEY_W                 sorted key value
// BEHAVIOUR
// - Reset: state=IDLE, addr=0, bank=0, rem=0; busy, done, out_valid, mem_rd_en and mem_wr_en are 0.
// - Reset: out_data, mem_rd_addr and mem_wr_addr are 0.
// - Reset mid-scan aborts immediately; no done pulse; the memory is not touched further.
// - FSM states: IDLE, READ, WAIT, EMIT, DONE.
// - IDLE: start=1 -> READ with addr=0.
// - READ: mem_rd_en=all ones, mem_rd_addr=addr; next state WAIT.
// - WAIT: latch mem_rd_data into row_buf; bank=0; rem=count of bank 0; next state EMIT.
// - EMIT, rem!=0: out_valid=1 and out_data={addr,bank}.
// - EMIT, rem!=0, on out_valid&out_ready: rem-=1.
// - EMIT, rem reaches 0 by that handshake: advance the bank in the same edge.
// - EMIT, rem==0: out_valid=0; advance the bank (one idle cycle per zero-count bank).
// - Advance bank, bank<NUM_BANKS-1: bank+=1; rem=row_buf[bank+1].
// - Advance bank, last bank, addr<max: addr+=1 -> READ.
// - Advance bank, last bank, addr==max: -> DONE (no address wrap).
// - DONE: done=1 for one cycle -> IDLE; busy drops in the same cycle.
// - out_data and out_valid are held stable while out_ready=0. No combinational path from out_ready to out_valid.
// - A count of 2**DATA_WIDTH-1 emits exactly that many keys; rem is DATA_WIDTH bits and never underflows.
// - start while busy is ignored.
// - Timing: with all counts 0, the scan takes (2+NUM_BANKS) cycles per address plus the DONE cycle.
// CONFIGURATION
// - Macro SORT_CNT_SCAN_CLR_EN, defined: in WAIT, mem_wr_en=all ones, mem_wr_addr=addr, mem_wr_data=0.
//   This zeroes each row as it is read, so the memory is clean for the next sort.
// - Macro SORT_CNT_SCAN_CLR_EN, undefined: mem_wr_en, mem_wr_addr and mem_wr_data are tied to 0.
//   Memory contents are preserved.
// TESTING (NUM_BANKS=2, ADDR_WIDTH=2, DATA_WIDTH=8, out_ready=1 unless stated)
// - Counts key1=2, key6=1, rest 0; pulse start -> out_data 1,1,6, then done.
//   No other out_valid cycles.
// - All counts 0; start at edge 0 -> out_valid never asserted; done high in cycle 17; busy low after.
// - key3=3 with out_ready toggling 1,0,0,1,0,1 -> exactly 3 handshakes of key 3.
//   out_data stays stable while stalled.
// - key0=255 -> exactly 255 outputs of key 0.
//   Then done; start pulsed during the scan has no effect.
// - rst asserted mid-EMIT of key5 -> next cycle all outputs 0, state IDLE, no done.
//   A new start rescans from addr 0.
// - With SORT_CNT_SCAN_CLR_EN: after a scan, all memory reads 0 and a second scan emits nothing.
// - Without SORT_CNT_SCAN_CLR_EN: a second scan repeats the identical key sequence.

Source files
------------

// File: rtl/sort_cnt_scan_if.sv
// Handshake and memory-port bundle between sort_cnt_scan and its environment.
// master: the scan engine; slave: the count memory plus the sorted-key consumer.
// Backpressure: out_ready stalls the key stream, and the memory ports have no flow control.
interface sort_cnt_scan_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 2
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int KEY_W  = ADDR_WIDTH + BANK_W;

    logic                            start;
    logic                            busy;
    logic                            done;
    logic [NUM_BANKS-1:0]            mem_rd_en;
    logic [ADDR_WIDTH-1:0]           mem_rd_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0] mem_rd_data;
    logic [NUM_BANKS-1:0]            mem_wr_en;
    logic [ADDR_WIDTH-1:0]           mem_wr_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0] mem_wr_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [KEY_W-1:0]                out_data;

    modport master (
        input  start,
        output busy, done,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        output start,
        input  busy, done,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/sort_cnt_scan.sv
// Counting-sort read engine: scans the count memory and emits each key once per stored count, in ascending order.
// Latency: (2+NUM_BANKS) cycles per address, plus one cycle per extra count, plus a DONE cycle.
// Backpressure: out_ready=0 holds out_valid/out_data. Macro SORT_CNT_SCAN_CLR_EN clears each row as it is read.
module sort_cnt_scan #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    sort_cnt_scan_if.master  bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int KEY_W  = ADDR_WIDTH + BANK_W;

    typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;

    state_t                          state, state_nxt;
    logic [ADDR_WIDTH-1:0]           addr, addr_nxt;
    logic [BANK_W-1:0]               bank, bank_nxt, bank_inc;
    logic [DATA_WIDTH-1:0]           rem, rem_nxt;
    logic [NUM_BANKS*DATA_WIDTH-1:0] row_buf, row_nxt;
    logic                            last_bank, last_addr, advance;

    assign bank_inc  = bank + BANK_W'(1);
    assign last_bank = (bank == BANK_W'(NUM_BANKS - 1));
    assign last_addr = &addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            bank    <= '0;
            rem     <= '0;
            row_buf <= '0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            bank    <= bank_nxt;
            rem     <= rem_nxt;
            row_buf <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        bank_nxt  = bank;
        rem_nxt   = rem;
        row_nxt   = row_buf;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = READ;
                    addr_nxt  = '0;
                end
            end
            READ: state_nxt = WAIT;
            WAIT: begin
                row_nxt   = bus.mem_rd_data;
                bank_nxt  = '0;
                rem_nxt   = bus.mem_rd_data[DATA_WIDTH-1:0];
                state_nxt = EMIT;
            end
            EMIT: begin
                if (rem == '0) begin
                    advance = 1'b1;
                end else if (bus.out_ready) begin
                    rem_nxt = rem - DATA_WIDTH'(1);
                    advance = (rem == DATA_WIDTH'(1));
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The final handshake of a bank moves on in the same edge, so no bubble per key run.
        if (advance) begin
            if (!last_bank) begin
                bank_nxt = bank_inc;
                rem_nxt  = row_buf[bank_inc*DATA_WIDTH +: DATA_WIDTH];
            end else if (!last_addr) begin
                addr_nxt  = addr + ADDR_WIDTH'(1);
                state_nxt = READ;
            end else begin
                state_nxt = DONE;
            end
        end
    end

    assign bus.busy        = (state == READ) || (state == WAIT) || (state == EMIT);
    assign bus.done        = (state == DONE);
    assign bus.mem_rd_en   = {NUM_BANKS{state == READ}};
    assign bus.mem_rd_addr = (state == READ) ? addr : '0;
    assign bus.out_valid   = (state == EMIT) && (rem != '0);
    assign bus.out_data    = KEY_W'({addr, bank});

`ifdef SORT_CNT_SCAN_CLR_EN
    assign bus.mem_wr_en   = {NUM_BANKS{state == WAIT}};
    assign bus.mem_wr_addr = (state == WAIT) ? addr : '0;
    assign bus.mem_wr_data = '0;
`else
    assign bus.mem_wr_en   = '0;
    assign bus.mem_wr_addr = '0;
    assign bus.mem_wr_data = '0;
`endif
endmodule

// File: tb/tb_sort_cnt_scan.sv
// Directed bench for sort_cnt_scan with a 4x2 count memory model and a key scoreboard.
module tb_sort_cnt_scan;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NB = 2;
    localparam int KW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sort_cnt_scan_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();

    sort_cnt_scan #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Count memory: key k lives in byte k, so address a is bits [16a +: 16].
    logic [63:0] mem_vec;
    logic [63:0] load_vec;
    logic        load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            mem_vec <= load_vec;
        end else begin
            for (int b = 0; b < NB; b++)
                if (bus.mem_wr_en[b]) mem_vec[bus.mem_wr_addr*16 + b*8 +: 8] <= bus.mem_wr_data[b*8 +: 8];
        end
        if (rst)                 bus.mem_rd_data <= '0;
        else if (bus.mem_rd_en[0]) bus.mem_rd_data <= mem_vec[bus.mem_rd_addr*16 +: 16];
    end

    int   got[$];
    logic collect = 1'b0;
    always @(posedge clk)
        if (collect && bus.out_valid && bus.out_ready) got.push_back(int'(bus.out_data));

    logic          stall_chk = 1'b0;
    logic          held_stall = 1'b0;
    logic [KW-1:0] held_dat = '0;
    always @(posedge clk) begin
        held_stall <= stall_chk && bus.out_valid && !bus.out_ready;
        held_dat   <= bus.out_data;
    end
    always @(negedge clk) begin
        if (held_stall) begin
            total++;
            if (!bus.out_valid || bus.out_data != held_dat) begin
                bad++;
                $display("FAIL stall_hold: valid=%0b data=%0d, want valid=1 data=%0d",
                         bus.out_valid, bus.out_data, held_dat);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"},      int'(bus.busy), 0);
        chk({nm, "_done"},      int'(bus.done), 0);
        chk({nm, "_valid"},     int'(bus.out_valid), 0);
        chk({nm, "_data"},      int'(bus.out_data), 0);
        chk({nm, "_rd_en"},     int'(bus.mem_rd_en), 0);
        chk({nm, "_rd_addr"},   int'(bus.mem_rd_addr), 0);
        chk({nm, "_wr_en"},     int'(bus.mem_wr_en), 0);
        chk({nm, "_wr_addr"},   int'(bus.mem_wr_addr), 0);
    endtask

    task automatic load_mem(input logic [63:0] cnt);
        load_vec = cnt;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // ncyc counts negedges after the edge that samples start; done must be high on that one.
    task automatic run_scan(input string nm, input logic [63:0] cnt, input bit do_load,
                            input int nk, input logic [23:0] keys, input int ncyc);
        int cyc;
        if (do_load) load_mem(cnt);
        got.delete();
        collect = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        chk({nm, "_busy_start"}, int'(bus.busy), 1);
        while (!bus.done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_cycles"}, cyc, ncyc);
        chk({nm, "_busy_at_done"}, int'(bus.busy), 0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, int'(bus.done), 0);
        collect = 1'b0;
        chk({nm, "_nkeys"}, got.size(), nk);
        for (int i = 0; i < nk && i < got.size(); i++)
            chk($sformatf("%s_key%0d", nm, i), got[i], int'(keys[i*3 +: 3]));
    endtask

    typedef struct {
        string       nm;
        logic [63:0] cnt;
        int          nk;
        logic [23:0] keys;
        int          ncyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        int nz;
        int dn;

        vecs[0] = '{"k1x2_k6x1", 64'h0001_0000_0000_0200, 3, {15'd0, 3'd6, 3'd1, 3'd1}, 18};
        vecs[1] = '{"all_zero",  64'h0000_0000_0000_0000, 0, 24'd0, 17};
        vecs[2] = '{"k0_k4_k7x2", 64'h0200_0001_0000_0001, 4, {12'd0, 3'd7, 3'd7, 3'd4, 3'd0}, 18};
        vecs[3] = '{"all_one",   64'h0101_0101_0101_0101, 8,
                    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 17};
        vecs[4] = '{"k2x3_k5x2", 64'h0000_0200_0003_0000, 5, {9'd0, 3'd5, 3'd5, 3'd2, 3'd2, 3'd2}, 20};

        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        load_vec = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        load_mem(64'd0);

        for (int v = 0; v < 5; v++)
            run_scan(vecs[v].nm, vecs[v].cnt, 1'b1, vecs[v].nk, vecs[v].keys, vecs[v].ncyc);

        // Second scan over untouched memory: repeats, or emits nothing if rows are cleared.
        run_scan("first", vecs[0].cnt, 1'b1, vecs[0].nk, vecs[0].keys, vecs[0].ncyc);
`ifdef SORT_CNT_SCAN_CLR_EN
        chk("mem_cleared", int'(mem_vec != 64'd0), 0);
        run_scan("second", 64'd0, 1'b0, 0, 24'd0, 17);
`else
        chk("mem_kept", int'(mem_vec == vecs[0].cnt), 1);
        run_scan("second", 64'd0, 1'b0, vecs[0].nk, vecs[0].keys, vecs[0].ncyc);
`endif

        // key3=3 under a ready pattern 1,0,0,1,0,1 from the first valid cycle.
        load_mem(64'h0000_0000_0300_0000);
        got.delete();
        collect = 1'b1;
        stall_chk = 1'b1;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_valid_seen", int'(bus.out_valid), 1);
        begin
            logic [5:0] pat;
            pat = 6'b101001;
            for (int i = 0; i < 6; i++) begin
                bus.out_ready = pat[i];
                @(negedge clk);
            end
        end
        bus.out_ready = 1'b1;
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_done_seen", int'(bus.done), 1);
        @(negedge clk);
        stall_chk = 1'b0;
        collect = 1'b0;
        chk("stall_nkeys", got.size(), 3);
        nz = 0;
        foreach (got[i]) if (got[i] != 3) nz++;
        chk("stall_wrong_keys", nz, 0);

        // key0=255 with a stray start in the middle of the scan.
        load_mem(64'h0000_0000_0000_00FF);
        got.delete();
        collect = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 2000) begin
            bus.start = (cyc == 100);
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        chk("max_cycles", cyc, 271);
        @(negedge clk);
        collect = 1'b0;
        chk("max_nkeys", got.size(), 255);
        nz = 0;
        foreach (got[i]) if (got[i] != 0) nz++;
        chk("max_wrong_keys", nz, 0);
        repeat (4) @(negedge clk);
        chk("max_no_restart", int'(bus.busy), 0);

        // Reset while key5 is on the output.
        load_mem(64'h0000_0400_0000_0000);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.out_valid && bus.out_data == 3'd5) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_key5_seen", int'(bus.out_valid && bus.out_data == 3'd5), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        chk("midrst_quiet", dn, 0);
        run_scan("rescan", 64'h0000_0100_0000_0001, 1'b1, 2, {18'd0, 3'd5, 3'd0}, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
